load_ext_pipe: RTL
==================

// Module: load_ext_pipe
// PURPOSE
//  Parametrised, registered load-data extender between the DM read port and the W stage.
//  Selects the byte, halfword or word lane from the DM read word using the low address bits.
//  Zero- or sign-extends the lane and flags misaligned or illegal loads.
//  Decoupled by a valid/ready handshake with a 2-entry skid buffer; counts retired loads.
// PARAMETERS
//  DATA_W   32  DM word / result width; only 32 and 64 are legal
//  TAG_W    5   destination-register tag carried alongside the data
//  CNT_W    32  width of the retired-load counter
// PORTS
//  clk        in   1          single clock; all state updates on its rising edge
//  reset      in   1          synchronous, active-high
//  flush      in   1          synchronous pipeline flush; drops every buffered entry
//  in_valid   in   1          request valid
//  in_ready   out  1          buffer can accept a request this cycle
//  in_data    in   DATA_W     raw DM read word, little-endian (addr 0 = bits [7:0])
//  in_addr    in   log2(DATA_W/8)  low byte-address bits
//  in_op      in   4          0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWU, 6 LD, 7 LWL, 8 LWR; 9-15 illegal
//  in_rt      in   32         old rt value; used by LWL/LWR only
//  in_tag     in   TAG_W      destination tag
//  out_valid  out  1          result valid
//  out_ready  in   1          consumer accepts the result
//  out_data   out  DATA_W     extended result
//  out_tag    out  TAG_W      tag of the result
//  out_err    out  1          misaligned or illegal op; out_data is 0 when set
//  load_cnt   out  CNT_W      number of results accepted at the output
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_tag=0, out_err=0, load_cnt=0; buffer count=0, so in_ready=1 after reset.
//  - Storage is a 2-entry FIFO (head = output register, skid = second entry).
//    Buffer states are EMPTY, ONE and FULL.
//  - in_ready = (state != FULL). It is registered and does not depend combinationally on out_ready.
//  - A push occurs when in_valid && in_ready. A pop occurs when out_valid && out_ready.
//  - Latency: a push in cycle N is visible on out_* in cycle N+1 if the buffer was EMPTY, or was ONE with a pop.
//  - Transitions:
//    - EMPTY + push -> ONE.
//    - ONE: push without pop -> FULL; pop without push -> EMPTY; push and pop together -> ONE (skid data moves to head).
//    - FULL + pop -> ONE (skid moves to head). A push is impossible while FULL.
//  - Result is computed at push time and stored already extended. Let s = in_addr.
//    - LB/LBU: byte s, sign-/zero-extended to DATA_W.
//    - LH/LHU: halfword s[..:1].
//    - LW: word lane s[..:2], sign-extended.
//    - LWU: same lane, zero-extended.
//    - LD: the full word.
//  - Errors (out_err=1, out_data=0, tag still carried):
//    - LH/LHU with s[0]=1.
//    - LW/LWU/LWL/LWR with s[1:0]!=0 for lanes that require alignment (LWL/LWR are exempt, see CONFIGURATION).
//    - LD with s!=0.
//    - LD or LWU when DATA_W=32.
//    - Any op of 9 or above.
//  - The error counts as a result: it occupies a slot and increments load_cnt when popped.
//  - Holding: while out_valid && !out_ready, out_* stay stable.
//  - load_cnt increments by 1 on every pop and wraps modulo 2^CNT_W.
//  - flush: count -> 0 and out_valid -> 0 next cycle. A push in the same cycle is dropped.
//    A pop in the same cycle still increments load_cnt.
//  - reset takes priority over flush. Reset mid-transfer discards all entries.
// CONFIGURATION
//  - LOAD_EXT_LWLR_EN defined (legal only with DATA_W=32):
//    - Ops 7/8 are legal for any s, with a = s[1:0] and w = in_data.
//    - LWL = (w << 8*(3-a)) | (in_rt & ~(32'hFFFFFFFF << 8*(3-a))).
//    - LWR = (w >> 8*a) | (in_rt & ~(32'hFFFFFFFF >> 8*a)).
//  - LOAD_EXT_LWLR_EN not defined: ops 7/8 are illegal (out_err=1), and in_rt is ignored.
// TESTING
//  - T1: reset; push LB, in_data=32'h0000_80FF, addr=1 -> next cycle out_data=32'hFFFF_FF80, err=0, load_cnt=1 after pop.
//  - T2: LHU, data=32'h8001_1234, addr=2 -> 32'h0000_8001; LH, addr=1 -> out_err=1, out_data=0.
//  - T3: hold out_ready=0, push 3 back-to-back.
//    - in_ready drops after the 2nd push; the 3rd is not accepted.
//    - Release out_ready -> results pop in order, load_cnt=2.
//  - T4: FULL, then flush and in_valid both high in the same cycle -> next cycle out_valid=0, in_ready=1, load_cnt unchanged.
//  - T5: CNT_W=4, 17 pops -> load_cnt=1. DATA_W=64, LD addr=0 -> full word; LD addr=4 -> err.
//  - T6 (LOAD_EXT_LWLR_EN): w=32'hAABBCCDD, rt=32'h11223344.
//    - LWL a=1 -> 32'hCCDD3344.
//    - LWR a=1 -> 32'h11AABBCC.
//    - Without the macro, both set out_err=1.

Source files
------------

// File: rtl/load_ext_pipe.sv
// load_ext_pipe
//   Registered load-data extender sitting between the data-memory read port and
//   the write-back stage. The byte / halfword / word lane is picked from the raw
//   read word using the low address bits. The lane is zero- or sign-extended,
//   and misaligned or illegal loads are flagged. Results are stored already
//   extended in a 2-entry FIFO. The head entry is the output register and the
//   second entry is a skid slot. The block also counts retired loads.
//
//   Optional feature: define LOAD_EXT_LWLR_EN to enable the LWL/LWR merge ops
//   (7/8). This is meaningful only with DATA_W=32. When the macro is undefined,
//   ops 7/8 report an error and in_rt is ignored.
//
// Parameters
//   DATA_W  data-memory word / result width (32 or 64)
//   TAG_W   destination-register tag width
//   CNT_W   retired-load counter width
//
// Ports
//   clk        clock, all state changes on the rising edge
//   reset      synchronous active-high reset
//   flush      synchronous flush, drops every buffered entry
//   in_valid   request valid
//   in_ready   buffer can accept a request (decoded from state only)
//   in_data    raw read word, little-endian
//   in_addr    low byte-address bits
//   in_op      0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWU, 6 LD, 7 LWL, 8 LWR
//   in_rt      old rt value for LWL/LWR
//   in_tag     destination tag
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   out_data   extended result (0 when out_err is set)
//   out_tag    tag of the result
//   out_err    misaligned or illegal op
//   load_cnt   number of results popped at the output (wraps)
module load_ext_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int CNT_W  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  input  logic [$clog2(DATA_W/8)-1:0]  in_addr,
  input  logic [3:0]                   in_op,
  input  logic [31:0]                  in_rt,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [TAG_W-1:0]             out_tag,
  output logic                         out_err,
  output logic [CNT_W-1:0]             load_cnt
);

  localparam int AW = $clog2(DATA_W/8);

  localparam logic [3:0] OP_LW  = 4'd0;
  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LWU = 4'd5;
  localparam logic [3:0] OP_LD  = 4'd6;
  localparam logic [3:0] OP_LWL = 4'd7;
  localparam logic [3:0] OP_LWR = 4'd8;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  // ---------------------------------------------------------------------------
  // Extension helpers
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_W-1:0] ext8(input logic [7:0] v, input logic sgn);
    logic [DATA_W-1:0] r;
    r      = {DATA_W{sgn & v[7]}};
    r[7:0] = v;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] ext16(input logic [15:0] v, input logic sgn);
    logic [DATA_W-1:0] r;
    r       = {DATA_W{sgn & v[15]}};
    r[15:0] = v;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] ext32(input logic [31:0] v, input logic sgn);
    logic [DATA_W-1:0] r;
    r       = {DATA_W{sgn & v[31]}};
    r[31:0] = v;
    return r;
  endfunction

`ifdef LOAD_EXT_LWLR_EN
  // Unaligned-word merges: the loaded bytes land in the high (LWL) or low (LWR)
  // end of rt, and the remaining rt bytes are kept.
  function automatic logic [31:0] merge_lwl(input logic [31:0] w, input logic [31:0] rt,
                                            input logic [1:0] a);
    logic [4:0] sh;
    sh = {~a, 3'b000};
    return (w << sh) | (rt & ~(32'hFFFF_FFFF << sh));
  endfunction

  function automatic logic [31:0] merge_lwr(input logic [31:0] w, input logic [31:0] rt,
                                            input logic [1:0] a);
    logic [4:0] sh;
    sh = {a, 3'b000};
    return (w >> sh) | (rt & ~(32'hFFFF_FFFF >> sh));
  endfunction
`else
  logic unused_rt;
  assign unused_rt = ^in_rt;
`endif

  // ---------------------------------------------------------------------------
  // Stage p0: lane select and extension at push time
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] res_data_p0;
  logic              res_err_p0;
  logic [AW+2:0]     bidx, hidx, widx;

  always_comb begin
    res_data_p0 = '0;
    res_err_p0  = 1'b0;
    // Bit offsets of the addressed byte, halfword and word lanes.
    bidx        = {in_addr, 3'b000};
    hidx        = bidx;
    hidx[3:0]   = 4'b0000;
    widx        = bidx;
    widx[4:0]   = 5'b00000;
    case (in_op)
      OP_LB:  res_data_p0 = ext8(in_data[bidx +: 8], 1'b1);
      OP_LBU: res_data_p0 = ext8(in_data[bidx +: 8], 1'b0);
      OP_LH, OP_LHU: begin
        if (in_addr[0]) res_err_p0 = 1'b1;
        else            res_data_p0 = ext16(in_data[hidx +: 16], in_op == OP_LH);
      end
      OP_LW: begin
        if (in_addr[1:0] != 2'b00) res_err_p0 = 1'b1;
        else                       res_data_p0 = ext32(in_data[widx +: 32], 1'b1);
      end
      OP_LWU: begin
        // A zero-extending word load has no meaning on a 32-bit datapath.
        if (DATA_W == 32 || in_addr[1:0] != 2'b00) res_err_p0 = 1'b1;
        else                                       res_data_p0 = ext32(in_data[widx +: 32], 1'b0);
      end
      OP_LD: begin
        if (DATA_W == 32 || in_addr != '0) res_err_p0 = 1'b1;
        else                               res_data_p0 = in_data;
      end
`ifdef LOAD_EXT_LWLR_EN
      OP_LWL: begin
        if (DATA_W != 32) res_err_p0 = 1'b1;
        else res_data_p0[31:0] = merge_lwl(in_data[31:0], in_rt, in_addr[1:0]);
      end
      OP_LWR: begin
        if (DATA_W != 32) res_err_p0 = 1'b1;
        else res_data_p0[31:0] = merge_lwr(in_data[31:0], in_rt, in_addr[1:0]);
      end
`else
      OP_LWL, OP_LWR: res_err_p0 = 1'b1;
`endif
      default: res_err_p0 = 1'b1;
    endcase
    if (res_err_p0) res_data_p0 = '0;
  end

  // ---------------------------------------------------------------------------
  // Buffer control: EMPTY / ONE / FULL
  // ---------------------------------------------------------------------------
  state_t state, state_nxt;
  logic   vld_p1;
  logic   push, pop;
  logic   load_head, load_skid, skid_to_head;

  assign vld_p1    = (state != EMPTY);
  assign out_valid = vld_p1;
  // Depends only on the state register, so there is no combinational path
  // from out_ready back to in_ready.
  assign in_ready  = (state != FULL);
  assign push      = in_valid && in_ready;
  assign pop       = vld_p1 && out_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    load_head    = 1'b0;
    load_skid    = 1'b0;
    skid_to_head = 1'b0;
    if (flush) begin
      // A push in the flush cycle is discarded along with the buffer.
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state_nxt = ONE;
            load_head = 1'b1;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (!push && pop) begin
            state_nxt = EMPTY;
          end else if (push && pop) begin
            // Head drains while the new result enters straight behind it.
            load_head = 1'b1;
          end
        end
        FULL: begin
          if (pop) begin
            state_nxt    = ONE;
            skid_to_head = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: head (output) register and skid entry
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] head_data_p1, skid_data_p1;
  logic [TAG_W-1:0]  head_tag_p1,  skid_tag_p1;
  logic              head_err_p1,  skid_err_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      head_data_p1 <= '0;
      head_tag_p1  <= '0;
      head_err_p1  <= 1'b0;
    end else if (load_head) begin
      head_data_p1 <= res_data_p0;
      head_tag_p1  <= in_tag;
      head_err_p1  <= res_err_p0;
    end else if (skid_to_head) begin
      head_data_p1 <= skid_data_p1;
      head_tag_p1  <= skid_tag_p1;
      head_err_p1  <= skid_err_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_data_p1 <= res_data_p0;
      skid_tag_p1  <= in_tag;
      skid_err_p1  <= res_err_p0;
    end
  end

  assign out_data = head_data_p1;
  assign out_tag  = head_tag_p1;
  assign out_err  = head_err_p1;

  // Retired-load counter; a pop in a flush cycle still retires.
  always_ff @(posedge clk) begin
    if (reset)    load_cnt <= '0;
    else if (pop) load_cnt <= load_cnt + CNT_W'(1);
  end

endmodule
